// File: rtl/rand_pick_if.sv
// rand_pick_if
//   Request/result bundle for rand_pick.
//   rnd   : free-running 32-bit LFSR word (only the low W bits are used)
//   req   : request, taken only while the picker is idle
//   range : number of legal indices, captured together with an accepted req
//   busy  : picker is working on a request
//   valid : one-cycle pulse, index/err hold the new result
//   index : picked index, held until the next valid
//   err   : result came from a range of zero, held with index
interface rand_pick_if #(
    parameter int W = 8
);
    logic [31:0]  rnd;
    logic         req;
    logic [W-1:0] range;
    logic         busy;
    logic         valid;
    logic [W-1:0] index;
    logic         err;

    // master drives requests (game logic / bench), slave is the picker
    modport master (
        output rnd, req, range,
        input  busy, valid, index, err
    );

    modport slave (
        input  rnd, req, range,
        output busy, valid, index, err
    );
endinterface

// File: rtl/rand_pick.sv
// rand_pick
//   Turns the free-running LFSR word into an unbiased index in [0, range-1]
//   using mask-and-reject sampling. An optional no-immediate-repeat rule
//   rejects a candidate equal to the previous pick. After MAX_TRIES rejected
//   draws the current word is reduced by repeated subtraction, so every
//   request completes in bounded time.
//
// Ports
//   clk         : clock, all state on the rising edge
//   reset       : asynchronous, active-low
//   bus         : rand_pick_if slave (rnd, req, range in; busy, valid, index, err out)
//   o_dbg_state : current FSM state, for observation only
//
// Handshake: req is sampled only while idle (busy=0, valid=0); a req seen
// in any other state is ignored, there is no back-pressure. The result is
// announced by a single-cycle valid pulse; index/err stay stable until the
// next pulse.
module rand_pick #(
    parameter int W         = 8,
    parameter int MAX_TRIES = 16,
    parameter int NO_REPEAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    rand_pick_if.slave  bus,
    output logic [2:0]  o_dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MASK     = 3'd1;
    localparam logic [2:0] S_DRAW     = 3'd2;
    localparam logic [2:0] S_FALLBACK = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int            TW           = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] LP_LAST_TRY  = TW'(MAX_TRIES - 1);
    localparam bit            LP_NO_REPEAT = (NO_REPEAT != 0);

    logic [2:0]    r_state;
    logic [W-1:0]  r_rng;
    logic [W-1:0]  r_mask;
    logic [TW-1:0] r_tries;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_last;
    logic          r_have_last;
    logic [W-1:0]  r_index;
    logic          r_err;

    logic [W-1:0]  w_cand;
    logic          w_draw_rep;
    logic          w_draw_ok;
    logic          w_fb_rep;
    logic [W-1:0]  w_acc_inc;
    logic [W-1:0]  w_fb_result;
    logic          w_unused_rnd;

    // Set every bit at or below the most significant set bit of v.
    function automatic logic [W-1:0] smear_right(input logic [W-1:0] v);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) begin
            m[i] = |(v >> i);
        end
        return m;
    endfunction

    assign w_unused_rnd = ^bus.rnd[31:W];

    // A draw is rejected when it falls outside the range, or when it would
    // repeat the previous pick (only meaningful with more than one index).
    assign w_cand     = bus.rnd[W-1:0] & r_mask;
    assign w_draw_rep = LP_NO_REPEAT && r_have_last && (w_cand == r_last) && (r_rng > W'(1));
    assign w_draw_ok  = (w_cand < r_rng) && !w_draw_rep;

    // Fallback repeat fix: step to the next index, wrapping to 0. acc < rng
    // so acc+1 cannot overflow W bits.
    assign w_fb_rep    = LP_NO_REPEAT && r_have_last && (r_acc == r_last) && (r_rng > W'(1));
    assign w_acc_inc   = r_acc + W'(1);
    assign w_fb_result = w_fb_rep ? ((w_acc_inc == r_rng) ? '0 : w_acc_inc) : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rng       <= '0;
            r_mask      <= '0;
            r_tries     <= '0;
            r_acc       <= '0;
            r_last      <= '0;
            r_have_last <= 1'b0;
            r_index     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_rng   <= bus.range;
                        r_tries <= '0;
                        r_state <= S_MASK;
                    end
                end
                S_MASK: begin
                    r_mask <= smear_right(r_rng - W'(1));
                    if (r_rng == '0) begin
                        // Empty range: report an error, previous pick untouched.
                        r_index <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_draw_ok) begin
                        r_index     <= w_cand;
                        r_err       <= 1'b0;
                        r_last      <= w_cand;
                        r_have_last <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_tries == LP_LAST_TRY) begin
                        r_acc   <= bus.rnd[W-1:0];
                        r_state <= S_FALLBACK;
                    end else begin
                        r_tries <= r_tries + TW'(1);
                    end
                end
                S_FALLBACK: begin
                    // One subtraction per cycle computes acc mod rng.
                    if (r_acc >= r_rng) begin
                        r_acc <= r_acc - r_rng;
                    end else begin
                        r_index     <= w_fb_result;
                        r_err       <= 1'b0;
                        r_last      <= w_fb_result;
                        r_have_last <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (r_state == S_MASK) || (r_state == S_DRAW) || (r_state == S_FALLBACK);
    assign bus.valid = (r_state == S_DONE);
    assign bus.index = r_index;
    assign bus.err   = r_err;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rand_pick.sv
module tb_rand_pick;

    localparam int W         = 8;
    localparam int MAX_TRIES = 16;
    localparam int NO_REPEAT = 1;
    localparam int TIMEOUT   = 300;
    localparam int NW        = TIMEOUT + 4;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rand_pick_if #(.W(W)) bus ();

    rand_pick #(
        .W(W),
        .MAX_TRIES(MAX_TRIES),
        .NO_REPEAT(NO_REPEAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    bit           exp_err_q[$];
    int           exp_lat_q[$];

    logic [31:0] words[0:NW-1];
    logic [31:0] script_q[$];

    // reference model state: previous pick
    int m_last      = 0;
    bit m_have_last = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: words[e] is the LFSR word present at edge k+e, k = accept edge.
    // Draw t uses the word at edge k+2+t.
    function automatic void predict(input int r, output int idx, output bit er, output int lat);
        int  mask;
        int  c;
        int  w;
        bit  found;
        idx   = 0;
        er    = 0;
        lat   = 0;
        found = 0;
        if (r == 0) begin
            idx = 0;
            er  = 1;
            lat = 2;
            return;
        end
        mask = 0;
        while (mask < r - 1) mask = mask * 2 + 1;
        for (int t = 0; t < MAX_TRIES && !found; t++) begin
            c = int'(words[2 + t][W-1:0]) & mask;
            if (c < r && !(NO_REPEAT != 0 && m_have_last && c == m_last && r > 1)) begin
                idx   = c;
                lat   = 3 + t;
                found = 1;
            end
        end
        if (!found) begin
            w   = int'(words[2 + MAX_TRIES - 1][W-1:0]);
            idx = w % r;
            lat = 3 + MAX_TRIES + w / r;
            if (NO_REPEAT != 0 && m_have_last && idx == m_last && r > 1) idx = (idx + 1) % r;
        end
        m_last      = idx;
        m_have_last = 1;
    endfunction

    // ---------------- driver ----------------
    // mode 0: random LFSR words, mode 1: constant word `fixed`.
    // Any words queued in script_q replace the words from edge k+2 onward.
    task automatic run_req(input int r, input int mode, input logic [31:0] fixed);
        int idx;
        int lat;
        bit er;
        int e;
        int busy_cnt;
        bit seen;
        int si;
        for (int i = 0; i < NW; i++) words[i] = (mode == 1) ? fixed : $urandom;
        si = 0;
        while (script_q.size() > 0) begin
            words[2 + si] = script_q.pop_front();
            si++;
        end
        predict(r, idx, er, lat);
        exp_q.push_back(W'(idx));
        exp_err_q.push_back(er);
        exp_lat_q.push_back(lat);

        @(negedge clk);
        bus.req   = 1'b1;
        bus.range = W'(r);
        bus.rnd   = words[0];
        e        = 0;
        busy_cnt = 0;
        seen     = 0;
        while (!seen && e < TIMEOUT) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                seen = 1;
            end else begin
                if (bus.busy) busy_cnt++;
                e++;
                @(negedge clk);
                bus.req   = 1'b0;
                bus.range = W'($urandom);   // must not affect the running request
                bus.rnd   = words[e];
            end
        end
        if (seen) begin
            check("index", 32'(bus.index), 32'(exp_q.pop_front()));
            check("err", 32'(bus.err), 32'(exp_err_q.pop_front()));
            check("latency", e + 1, exp_lat_q.pop_front());
            check("busy_cycles", busy_cnt, lat - 1);
            check("busy_at_valid", 32'(bus.busy), 0);
        end else begin
            check("timeout", 0, 1);
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
            void'(exp_lat_q.pop_front());
        end
        @(negedge clk);
        bus.req = 1'b0;
        bus.rnd = $urandom;
        @(posedge clk);
        #1;
        check("valid_pulse", 32'(bus.valid), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int mode;

        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.range = '0;
        bus.rnd   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_index", 32'(bus.index), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b1;

        // first-draw accept, then one reject
        script_q.push_back(32'h0000_0003);
        run_req(6, 0, 0);
        script_q.push_back(32'h0000_0007);
        script_q.push_back(32'h0000_0005);
        run_req(6, 0, 0);
        // empty range, then a normal request clears err
        run_req(0, 0, 0);
        script_q.push_back(32'h0000_0001);
        run_req(4, 0, 0);
        // repeat rule: last=3, draw 3 rejected, 4 accepted
        script_q.push_back(32'h0000_0003);
        run_req(6, 0, 0);
        script_q.push_back(32'h0000_0003);
        script_q.push_back(32'h0000_0004);
        run_req(6, 0, 0);
        // single-index range may repeat
        script_q.push_back(32'h0000_0000);
        run_req(4, 0, 0);
        script_q.push_back(32'h0000_0000);
        run_req(1, 0, 0);
        // forced fallback: 255 mod 5 = 0 equals last -> 1
        run_req(5, 1, 32'h0000_00FF);

        // reset in the middle of a draw sequence
        script_q.push_back(32'h0000_0002);
        run_req(4, 0, 0);
        script_q.push_back(32'h0000_0001);
        run_req(2, 0, 0);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.range = W'(5);
        bus.rnd   = 32'h0000_00FF;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_valid", 32'(bus.valid), 0);
        check("midrst_index", 32'(bus.index), 0);
        check("midrst_err", 32'(bus.err), 0);
        check("midrst_state", 32'(dbg_state), 0);
        m_last      = 0;
        m_have_last = 0;
        @(negedge clk);
        reset = 1'b1;
        script_q.push_back(32'h0000_0001);
        run_req(2, 0, 0);

        // randomized requests
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 8);
            else                           r = $urandom_range(0, 255);
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_req(r, mode, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
